lut_sweep_eval: RTL and testbench
=================================

// Module: lut_sweep_eval
// PURPOSE
//  Parametrised sequential boolean-function evaluator. Holds an N-input truth table and sweeps
//  every input combination 0..2^N-1, streaming (input vector, output bit) rows over a valid/ready
//  port and counting minterms. Serves as the self-checking engine behind the exercise benches:
//  it replaces fixed 4-input SOP gates and hand-written stimulus lists.
// PARAMETERS
//  N_IN     4           number of function inputs (1..8); row index MSB = first input
//  TT_W     2**N_IN     truth-table width (derived, localparam; not overridable)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  tt_load    in   1        load tt_data into table register (honoured in IDLE/DONE only)
//  tt_data    in   TT_W     truth table; bit i = function value for input vector i
//  start      in   1        begin a sweep (honoured in IDLE/DONE only)
//  busy       out  1        1 while state == RUN
//  out_valid  out  1        row available on out_vec/out_s
//  out_ready  in   1        consumer accepts row when out_valid && out_ready
//  out_vec    out  N_IN     input vector of current row
//  out_s      out  1        function value tt[out_vec]
//  done       out  1        one-cycle pulse after the last row is accepted
//  ones_cnt   out  N_IN+1   number of 1-rows in completed sweep; held until next start
// BEHAVIOUR
//  - Reset: state=IDLE, table=0, row=0, busy=0, out_valid=0, out_vec=0, out_s=0, done=0,
//    ones_cnt=0. Reset mid-sweep aborts immediately; no done pulse is issued.
//  - FSM: IDLE --start--> RUN; RUN --last row accepted--> DONE; DONE --(1 cycle)--> IDLE,
//    or DONE --start--> RUN directly. start in RUN is ignored.
//  - tt_load in RUN is ignored; the table is frozen for the whole sweep. If tt_load and start
//    are asserted together in IDLE/DONE, the load takes effect first and the sweep uses the new table.
//  - Latency: start sampled at edge k -> out_valid=1, out_vec=0 after edge k; ones_cnt cleared at edge k.
//  - Handshake: all outputs are registered. While out_valid && !out_ready, out_vec and out_s hold
//    stable. On accept, row increments and the next row is presented the following cycle (no bubble).
//    ones_cnt += out_s on each accept.
//  - Last row (out_vec == 2^N-1) accepted: out_valid drops, busy drops, done=1 for exactly one
//    cycle, and ones_cnt is final. The row counter is N_IN+1 bits wide and never wraps into a second pass.
//  - out_ready may be asserted while out_valid=0; it has no effect.
// CONFIGURATION
//  - LUT_SWEEP_SKIP_ZERO_EN defined: rows with out_s=0 are never presented. The counter steps over
//    them at one row per cycle with out_valid=0, so only minterms are streamed. An all-zero table
//    emits no rows and pulses done 2^N cycles after start, with ones_cnt=0.
//  - Undefined: every row is presented, and the row order is strictly ascending.
// STRUCTURE
//  - Package lut_sweep_pkg: state enum {S_IDLE, S_RUN, S_DONE}, N_IN_MAX=8, and the function
//    tt_bit(tt, idx).
//  - Sub-module lut_sweep_row_cnt: N_IN+1-bit row counter with clear, advance and last-row flag.
//  - The top level holds the FSM, the table register, the output register and ones_cnt.
// TESTING (N_IN=4 unless noted)
//  1 tt=16'h0F2A, start, out_ready=1 -> 16 rows, s=1 at vec 1,3,5,8,9,10,11, done once, ones_cnt=7.
//  2 same table, out_ready toggled 1/0 every cycle -> outputs held while stalled, 16 rows, ones_cnt=7.
//  3 rst asserted at row 6 -> next cycle all outputs at reset values, no done; new start sweeps from vec 0.
//  4 start and tt_load(16'hFFFF) pulsed at row 3 -> ignored; sweep still uses 16'h0F2A and ends with ones_cnt=7.
//  5 LUT_SWEEP_SKIP_ZERO_EN, tt=16'h0F2A -> 7 rows (1,3,5,8,9,10,11); tt=0 -> no rows, done at start+16.
//  6 N_IN=1, tt=2'b10 -> rows (0,0),(1,1), done, ones_cnt=1; start in DONE re-runs with no idle cycle.

Source files
------------

// File: rtl/lut_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep evaluator.
package lut_sweep_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   localparam int unsigned N_IN_MAX = 8;
   localparam int unsigned TT_W_MAX = 2**N_IN_MAX;

   function automatic logic tt_bit(input logic [TT_W_MAX-1:0] tt,
                                   input logic [N_IN_MAX-1:0] idx);
      return tt[idx];
   endfunction

endpackage

// File: rtl/lut_sweep_eval_if.sv
// Row stream port of the sweep evaluator: (out_vec, out_s) under valid/ready.
interface lut_sweep_eval_if #(
   parameter int unsigned N_IN = 4
) ();
   logic            out_valid;
   logic            out_ready;
   logic [N_IN-1:0] out_vec;
   logic            out_s;

   modport master (output out_valid, output out_vec, output out_s, input out_ready);
   modport slave  (input out_valid, input out_vec, input out_s, output out_ready);
endinterface

// File: rtl/lut_sweep_row_cnt.sv
// Row counter for the sweep; one bit wider than the row index so it never wraps.
module lut_sweep_row_cnt #(
   parameter int unsigned N_IN = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            adv,
   output logic [N_IN-1:0] vec,
   output logic            last
);
   localparam logic [N_IN:0] LastRow = (N_IN+1)'((1 << N_IN) - 1);

   logic [N_IN:0] row_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q <= '0;
      end else if (clr) begin
         row_q <= '0;
      end else if (adv) begin
         row_q <= row_q + (N_IN+1)'(1);
      end
   end

   assign vec  = row_q[N_IN-1:0];
   assign last = (row_q == LastRow);
endmodule

// File: rtl/lut_sweep_eval.sv
// Sequential truth-table evaluator: sweeps every input vector and streams (vec, value) rows.
// Define LUT_SWEEP_SKIP_ZERO_EN to stream only minterms (zero rows are stepped over silently).
module lut_sweep_eval
   import lut_sweep_pkg::*;
#(
   parameter int unsigned N_IN = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tt_load,
   input  logic [2**N_IN-1:0]  tt_data,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [N_IN:0]       ones_cnt,
   lut_sweep_eval_if.master    out_if
);
   localparam int unsigned TT_W = 2**N_IN;
`ifdef LUT_SWEEP_SKIP_ZERO_EN
   localparam bit SkipZero = 1'b1;
`else
   localparam bit SkipZero = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [TT_W-1:0]   tt_q, tt_d;
   logic              valid_q, valid_d;
   logic              s_q, s_d;
   logic              done_q, done_d;
   logic [N_IN:0]     ones_q, ones_d;

   logic              cnt_clr, cnt_adv, last;
   logic [N_IN-1:0]   vec, nxt_idx;
   logic              starting, accept, advance, nxt_bit;
   logic [TT_W_MAX-1:0] tt_ext;
   logic [N_IN_MAX-1:0] idx_ext;

   lut_sweep_row_cnt #(.N_IN(N_IN)) u_row_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .adv  (cnt_adv),
      .vec  (vec),
      .last (last)
   );

   always_comb begin
      state_d  = state_q;
      tt_d     = tt_q;
      valid_d  = valid_q;
      s_d      = s_q;
      done_d   = 1'b0;
      ones_d   = ones_q;
      cnt_clr  = 1'b0;
      cnt_adv  = 1'b0;
      starting = (state_q != S_RUN) && start;
      accept   = valid_q && out_if.out_ready;
      // In skip mode an unpresented row is stepped over without waiting for the consumer.
      advance  = accept || (SkipZero && !valid_q);

      // A load coinciding with start must be visible to the first row.
      if (state_q != S_RUN && tt_load) tt_d = tt_data;

      nxt_idx = starting ? '0 : vec + N_IN'(1);
      tt_ext  = '0;
      tt_ext[TT_W-1:0] = tt_d;
      idx_ext = '0;
      idx_ext[N_IN-1:0] = nxt_idx;
      nxt_bit = tt_bit(tt_ext, idx_ext);

      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (starting) begin
               state_d = S_RUN;
               cnt_clr = 1'b1;
               valid_d = SkipZero ? nxt_bit : 1'b1;
               s_d     = nxt_bit;
               ones_d  = '0;
            end
         end
         S_RUN: begin
            if (accept) ones_d = ones_q + {{N_IN{1'b0}}, s_q};
            if (advance) begin
               cnt_adv = 1'b1;
               if (last) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  s_d     = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  valid_d = SkipZero ? nxt_bit : 1'b1;
                  s_d     = nxt_bit;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tt_q    <= '0;
         valid_q <= 1'b0;
         s_q     <= 1'b0;
         done_q  <= 1'b0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         tt_q    <= tt_d;
         valid_q <= valid_d;
         s_q     <= s_d;
         done_q  <= done_d;
         ones_q  <= ones_d;
      end
   end

   assign busy             = (state_q == S_RUN);
   assign done             = done_q;
   assign ones_cnt         = ones_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_vec   = vec;
   assign out_if.out_s     = s_q;
endmodule

// File: tb/tb_lut_sweep_eval.sv
// Self-checking bench for lut_sweep_eval (N_IN=4 and N_IN=1 instances) against a row-list model.
module tb_lut_sweep_eval;
`ifdef LUT_SWEEP_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tt_load = 1'b0;
   logic [15:0] tt_data = '0;
   logic        start = 1'b0;
   logic        busy, done;
   logic [4:0]  ones_cnt;
   logic        tt1_load = 1'b0;
   logic [1:0]  tt1_data = '0;
   logic        start1 = 1'b0;
   logic        busy1, done1;
   logic [1:0]  ones1;
   int          passed = 0;
   int          total = 0;

   always #5 clk = ~clk;

   lut_sweep_eval_if #(.N_IN(4)) if4 ();
   lut_sweep_eval_if #(.N_IN(1)) if1 ();

   lut_sweep_eval #(.N_IN(4)) dut4 (
      .clk(clk), .rst(rst), .tt_load(tt_load), .tt_data(tt_data), .start(start),
      .busy(busy), .done(done), .ones_cnt(ones_cnt), .out_if(if4)
   );
   lut_sweep_eval #(.N_IN(1)) dut1 (
      .clk(clk), .rst(rst), .tt_load(tt1_load), .tt_data(tt1_data), .start(start1),
      .busy(busy1), .done(done1), .ones_cnt(ones1), .out_if(if1)
   );

   task automatic test_reset();
      rst = 1'b1;
      if4.out_ready = 1'b0;
      if1.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, if4.out_valid, if4.out_vec, if4.out_s, done, ones_cnt} !== 13'b0) begin
         $display("FAIL reset_n4 got %b want 0",
                  {busy, if4.out_valid, if4.out_vec, if4.out_s, done, ones_cnt});
      end else passed++;
      total++;
      if ({busy1, if1.out_valid, if1.out_vec, if1.out_s, done1, ones1} !== 7'b0) begin
         $display("FAIL reset_n1 got %b want 0",
                  {busy1, if1.out_valid, if1.out_vec, if1.out_s, done1, ones1});
      end else passed++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   // mode 0: ready always high, 1: toggling, 2: random. poke pulses start+load(FFFF) mid-sweep.
   task automatic run_sweep(input logic [15:0] tt, input int mode, input bit poke,
                            input string name);
      int   exp_vec[$];
      logic exp_s[$];
      int   exp_ones = 0;
      int   rows = 0;
      int   done_cyc = -1;
      logic prev_stall = 1'b0;
      logic [3:0] prev_vec = '0;
      logic prev_s = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!SKIP || tt[i]) begin
            exp_vec.push_back(i);
            exp_s.push_back(tt[i]);
         end
         if (tt[i]) exp_ones++;
      end
      @(negedge clk);
      tt_data = tt;
      tt_load = 1'b1;
      start = 1'b1;
      if4.out_ready = 1'b1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         tt_load = 1'b0;
         start = 1'b0;
         if (cyc == 0) begin
            total++;
            if (busy !== 1'b1) $display("FAIL %s start_busy got %b want 1", name, busy);
            else passed++;
            if (!SKIP) begin
               total++;
               if ({if4.out_valid, if4.out_vec} !== 5'b10000)
                  $display("FAIL %s first_row got %b want 10000", name,
                           {if4.out_valid, if4.out_vec});
               else passed++;
            end
         end
         if (prev_stall) begin
            total++;
            if ({if4.out_valid, if4.out_vec, if4.out_s} !== {1'b1, prev_vec, prev_s})
               $display("FAIL %s stall_hold got %b want %b", name,
                        {if4.out_valid, if4.out_vec, if4.out_s}, {1'b1, prev_vec, prev_s});
            else passed++;
         end
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         if (poke && cyc == 3) begin
            start = 1'b1;
            tt_load = 1'b1;
            tt_data = 16'hFFFF;
         end
         if (mode == 0) if4.out_ready = 1'b1;
         else if (mode == 1) if4.out_ready = (cyc % 2 == 0);
         else if4.out_ready = 1'($urandom_range(0, 1));
         if (if4.out_valid && if4.out_ready) begin
            total++;
            if (rows >= exp_vec.size()) begin
               $display("FAIL %s extra_row got vec %0d want no row", name, if4.out_vec);
            end else if ({if4.out_vec, if4.out_s} !== {4'(exp_vec[rows]), exp_s[rows]}) begin
               $display("FAIL %s row%0d got vec=%0d s=%b want vec=%0d s=%b", name, rows,
                        if4.out_vec, if4.out_s, exp_vec[rows], exp_s[rows]);
            end else passed++;
            rows++;
         end
         prev_stall = if4.out_valid && !if4.out_ready;
         prev_vec = if4.out_vec;
         prev_s = if4.out_s;
      end
      total++;
      if (done_cyc < 0) begin
         $display("FAIL %s timeout got no done want done", name);
         return;
      end else passed++;
      total++;
      if (rows !== exp_vec.size())
         $display("FAIL %s row_count got %0d want %0d", name, rows, exp_vec.size());
      else passed++;
      total++;
      if (ones_cnt !== 5'(exp_ones))
         $display("FAIL %s ones_cnt got %0d want %0d", name, ones_cnt, exp_ones);
      else passed++;
      total++;
      if ({if4.out_valid, busy} !== 2'b00)
         $display("FAIL %s end_flags got %b want 00", name, {if4.out_valid, busy});
      else passed++;
      if (mode == 0) begin
         total++;
         if (done_cyc !== 16) $display("FAIL %s done_time got %0d want 16", name, done_cyc);
         else passed++;
      end
      @(negedge clk);
      total++;
      if ({done, ones_cnt} !== {1'b0, 5'(exp_ones)})
         $display("FAIL %s done_pulse got %b want %b", name, {done, ones_cnt},
                  {1'b0, 5'(exp_ones)});
      else passed++;
   endtask

   task automatic test_reset_mid();
      int done_seen = 0;
      @(negedge clk);
      tt_data = 16'h0F2A;
      tt_load = 1'b1;
      start = 1'b1;
      if4.out_ready = 1'b1;
      repeat (7) begin
         @(negedge clk);
         tt_load = 1'b0;
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, if4.out_valid, if4.out_vec, if4.out_s, done, ones_cnt} !== 13'b0)
         $display("FAIL reset_mid got %b want 0",
                  {busy, if4.out_valid, if4.out_vec, if4.out_s, done, ones_cnt});
      else passed++;
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      total++;
      if (done_seen !== 0) $display("FAIL reset_mid_quiet got %0d want 0", done_seen);
      else passed++;
      run_sweep(16'h0F2A, 0, 1'b0, "after_reset");
   endtask

   task automatic test_n1();
      int   exp_vec[$];
      logic exp_s[$];
      int   rows;
      bit   seen;
      for (int i = 0; i < 2; i++) begin
         if (!SKIP || i == 1) begin
            exp_vec.push_back(i);
            exp_s.push_back(i == 1);
         end
      end
      @(negedge clk);
      tt1_data = 2'b10;
      tt1_load = 1'b1;
      start1 = 1'b1;
      if1.out_ready = 1'b1;
      for (int p = 0; p < 2; p++) begin
         rows = 0;
         seen = 1'b0;
         for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            tt1_load = 1'b0;
            start1 = 1'b0;
            if (cyc == 0) begin
               total++;
               if (busy1 !== 1'b1) $display("FAIL n1_busy pass%0d got %b want 1", p, busy1);
               else passed++;
            end
            if (done1 === 1'b1) begin
               seen = 1'b1;
               total++;
               if ({rows[1:0], ones1} !== {2'(exp_vec.size()), 2'd1})
                  $display("FAIL n1_end pass%0d got rows=%0d ones=%0d want rows=%0d ones=1",
                           p, rows, ones1, exp_vec.size());
               else passed++;
               if (p == 0) start1 = 1'b1;
               break;
            end
            if (if1.out_valid && if1.out_ready) begin
               total++;
               if (rows >= exp_vec.size())
                  $display("FAIL n1_extra_row got vec %0d want no row", if1.out_vec);
               else if ({if1.out_vec, if1.out_s} !== {1'(exp_vec[rows]), exp_s[rows]})
                  $display("FAIL n1_row%0d got vec=%0d s=%b want vec=%0d s=%b", rows,
                           if1.out_vec, if1.out_s, exp_vec[rows], exp_s[rows]);
               else passed++;
               rows++;
            end
         end
         total++;
         if (!seen) $display("FAIL n1_timeout pass%0d got no done want done", p);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      run_sweep(16'h0F2A, 0, 1'b0, "full");
      run_sweep(16'h0F2A, 1, 1'b0, "stall");
      test_reset_mid();
      run_sweep(16'h0F2A, 0, 1'b1, "ignore");
      run_sweep(16'h0000, 0, 1'b0, "zero");
      run_sweep(16'hFFFF, 1, 1'b0, "all_ones");
      for (int r = 0; r < 4; r++) run_sweep(16'($urandom), 2, 1'b0, "random");
      test_n1();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
